axis_processor_arbiter: RTL and testbench
=========================================

Name: axis_processor_arbiter

Overview:
- Shares one axis_processor_tlast instance between NUM_REQ independent AXI-Stream requesters.
- Grants the processor input to one requester per tlast-delimited packet, using round-robin order.
- Records the grant ID in an ordered ID FIFO and steers each returning processor output packet back to the requester that sent the matching input packet.
- Sits between the DMA/stream sources and the processor core. Its clock and reset are shared with the processor.

Parameters:
- NUM_REQ, 4, number of requesters, 2..16.
- ID_FIFO_DEPTH, 8, maximum number of outstanding packets (granted but response not yet finished); power of two.
- Data widths come from processor_tlast_config: INP_TDATA_WIDTH_BYTES (IW) and OUT_TDATA_WIDTH_BYTES (OW).

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_REQ  requester input valid, one bit per requester
- s_tready  out  NUM_REQ  requester input ready
- s_tdata  in  NUM_REQ*IW*8  requester data, flattened; requester i occupies slice i
- s_tkeep  in  NUM_REQ*IW  requester byte keep
- s_tlast  in  NUM_REQ  requester end of packet
- p_tvalid / p_tready / p_tdata[IW*8] / p_tkeep[IW] / p_tlast  out/in/out/out/out  to the processor's s_axis
- r_tvalid / r_tready / r_tdata[OW*8] / r_tkeep[OW] / r_tlast  in/out/in/in/in  from the processor's m_axis
- m_tvalid  out  NUM_REQ  response valid per requester
- m_tready  in  NUM_REQ  response ready per requester
- m_tdata  out  NUM_REQ*OW*8  response data; all slices carry r_tdata
- m_tkeep  out  NUM_REQ*OW  response keep; all slices carry r_tkeep
- m_tlast  out  NUM_REQ  response end of packet

Behaviour:
- Reset (arstn=0, asynchronous):
  - State goes to IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has priority first.
  - ID FIFO is emptied.
  - Outputs held at 0: s_tready, p_tvalid, r_tready, m_tvalid.
- Reset mid-packet discards the packet in flight and all outstanding IDs. The processor shares arstn and is cleared in the same reset.
- Forward FSM, state IDLE:
  - When any s_tvalid is high and the FIFO is not full, grant the first requester with valid high, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - On that edge: register grant, push grant into the FIFO, move to FWD.
  - Arbitration latency is one cycle. No s_tready is asserted while in IDLE.
- Forward FSM, state FWD:
  - Combinational pass-through: p_* = s_*[grant], s_tready[grant] = p_tready; all other s_tready bits are 0.
  - A beat transfers on p_tvalid & p_tready.
  - On a transferred beat with p_tlast=1: last_grant <= grant, return to IDLE.
- Grant is held for the whole packet. Deasserting s_tvalid mid-packet stalls the processor input; it does not cause re-arbitration.
- A single-beat packet (tlast on the first beat) gives exactly two cycles per packet: IDLE then FWD.
- FIFO full: IDLE waits and no grant is made. A packet already in FWD always completes.
- Return path:
  - When the FIFO is not empty, head = oldest ID; m_tvalid[head] = r_tvalid, m_tlast[head] = r_tlast, r_tready = m_tready[head].
  - All other m_tvalid and m_tlast bits are 0.
  - When the FIFO is empty, r_tready = 0 and all m_tvalid = 0.
  - Pop on the r handshake with r_tlast=1.
- The processor emits exactly one output packet per input packet, in input order. A response with no outstanding ID is held (r_tready=0) and is a protocol error.
- Push (on grant) and pop (on response tlast) in the same cycle are both performed and the FIFO count is unchanged. Pop precedes push for full detection, so a full FIFO with a pop this cycle allows a grant.
- Pointer and FIFO index arithmetic: $clog2 widths, wrapping modulo the size. The count is $clog2(ID_FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: AXIS_ARB_STATS_EN.
- Defined:
  - Adds output stat_pkts [NUM_REQ*32], a per-requester count of completed input packets (p tlast handshakes).
  - Adds output stat_stall [32], a count of cycles in IDLE where s_tvalid was nonzero but the FIFO was full.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Package axis_arb_pkg (imports processor_tlast_config): arb_state_t enum {IDLE, FWD}, and the function rr_pick(valid, last) returning the next grant index.
- Sub-module axis_arb_id_fifo: synchronous FIFO with push/pop/full/empty/head. Its width is $clog2(NUM_REQ) and its depth is ID_FIFO_DEPTH.

Test Plan:
- Basic grant:
  - Stimulus: after reset, requester 2 only sends a 3-beat packet, processor stub echoes 3 beats.
  - Required: grant=2 after 1 cycle, p beats match s_tdata[2]; m_tvalid=4'b0100 on all 3 response beats; FIFO empty afterwards.
- Round-robin order:
  - Stimulus: all 4 requesters continuously valid with 1-beat packets.
  - Required: grant sequence 0,1,2,3,0,1; responses return to m lanes in the same order.
- FIFO full:
  - Stimulus: processor r_tvalid held low; send 9 packets with ID_FIFO_DEPTH=8.
  - Required: exactly 8 grants, then IDLE with s_tready=0.
  - Then: release one response; the 9th packet is granted in the cycle of the pop.
- Backpressure:
  - Stimulus: m_tready[1]=0 while head=1.
  - Required: r_tready=0 and no data lost. Then raise m_tready[1]; the packet is delivered intact and the next head is served.
- Reset mid-packet:
  - Stimulus: arstn low during beat 2 of 4.
  - Required: all valid/ready outputs 0 asynchronously; after release, requester 0 is granted first.
- Statistics (with AXIS_ARB_STATS_EN):
  - Stimulus: the round-robin test run for 20 packets.
  - Required: stat_pkts = 5 for each requester.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the processor arbiter.
// Widths come from processor_tlast_config.
package axis_arb_pkg;
  import processor_tlast_config::*;

  localparam int IW      = INP_TDATA_WIDTH_BYTES;
  localparam int OW      = OUT_TDATA_WIDTH_BYTES;
  localparam int MAX_REQ = 16;

  typedef enum logic {
    IDLE,
    FWD
  } arb_state_t;

  // First valid requester after last, wrapping modulo n.
  function automatic int unsigned rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input int unsigned        last,
    input int unsigned        n
  );
    int unsigned idx;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = (last + i) % n;
      if (i <= n && !found && valid[idx[3:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/processor_tlast_config.sv
// Stream widths of the shared tlast processor core.
// Byte counts for its input and output tdata buses.
package processor_tlast_config;
  localparam int INP_TDATA_WIDTH_BYTES = 4;
  localparam int OUT_TDATA_WIDTH_BYTES = 4;
endpackage

// File: rtl/axis_arb_id_fifo.sv
// Ordered FIFO of grant IDs awaiting their processor response.
// Pop is honoured before push when judging full.
module axis_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
    if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/axis_processor_arbiter.sv
// Round-robin packet arbiter sharing one tlast processor.
// Optional counters: define AXIS_ARB_STATS_EN.
module axis_processor_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic [NUM_REQ-1:0]        s_tvalid,
  output logic [NUM_REQ-1:0]        s_tready,
  input  logic [NUM_REQ*IW*8-1:0]   s_tdata,
  input  logic [NUM_REQ*IW-1:0]     s_tkeep,
  input  logic [NUM_REQ-1:0]        s_tlast,
  output logic                      p_tvalid,
  input  logic                      p_tready,
  output logic [IW*8-1:0]           p_tdata,
  output logic [IW-1:0]             p_tkeep,
  output logic                      p_tlast,
  input  logic                      r_tvalid,
  output logic                      r_tready,
  input  logic [OW*8-1:0]           r_tdata,
  input  logic [OW-1:0]             r_tkeep,
  input  logic                      r_tlast,
  output logic [NUM_REQ-1:0]        m_tvalid,
  input  logic [NUM_REQ-1:0]        m_tready,
  output logic [NUM_REQ*OW*8-1:0]   m_tdata,
  output logic [NUM_REQ*OW-1:0]     m_tkeep,
  output logic [NUM_REQ-1:0]        m_tlast
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_pkts,
  output logic [31:0]               stat_stall
`endif
);
  localparam int GW = $clog2(NUM_REQ);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] head;
  logic          full, empty, push, pop;

  axis_arb_id_fifo #(
    .W     (GW),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_ids (
    .clk     (clk),
    .arstn   (arstn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (grant_d),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Responses follow the oldest outstanding ID.
  always_comb begin
    m_tvalid = '0;
    m_tlast  = '0;
    r_tready = 1'b0;
    if (!empty) begin
      m_tvalid[head] = r_tvalid;
      m_tlast[head]  = r_tlast;
      r_tready       = m_tready[head];
    end
  end

  assign pop     = r_tvalid & r_tready & r_tlast;
  assign m_tdata = {NUM_REQ{r_tdata}};
  assign m_tkeep = {NUM_REQ{r_tkeep}};

  assign p_tdata = s_tdata[grant_q*IW*8 +: IW*8];
  assign p_tkeep = s_tkeep[grant_q*IW +: IW];
  assign p_tlast = s_tlast[grant_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    push     = 1'b0;
    s_tready = '0;
    p_tvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|s_tvalid && (!full || pop)) begin
          grant_d = GW'(rr_pick(MAX_REQ'(s_tvalid),
                                32'(last_q),
                                NUM_REQ));
          push    = 1'b1;
          state_d = FWD;
        end
      end
      FWD: begin
        p_tvalid          = s_tvalid[grant_q];
        s_tready[grant_q] = p_tready;
        if (p_tvalid && p_tready && p_tlast) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] stat_pkts_q;
  logic [31:0]           stat_stall_q;

  assign stat_pkts  = stat_pkts_q;
  assign stat_stall = stat_stall_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (p_tvalid && p_tready && p_tlast)
        stat_pkts_q[grant_q*32 +: 32] <=
          stat_pkts_q[grant_q*32 +: 32] + 32'd1;
      if (state_q == IDLE && |s_tvalid && full && !pop)
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Randomized bench for axis_processor_arbiter with a stub processor.
// Scoreboard predicts round-robin grants and response routing.
module tb_axis_processor_arbiter;
  import axis_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = IW * 8;
  localparam int RW    = OW * 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [RW-1:0] d;
    logic          l;
  } rbeat_t;

  logic                   clk;
  logic                   arstn;
  logic [NREQ-1:0]        s_tvalid;
  logic [NREQ-1:0]        s_tready;
  logic [NREQ*DW-1:0]     s_tdata;
  logic [NREQ*IW-1:0]     s_tkeep;
  logic [NREQ-1:0]        s_tlast;
  logic                   p_tvalid;
  logic                   p_tready;
  logic [DW-1:0]          p_tdata;
  logic [IW-1:0]          p_tkeep;
  logic                   p_tlast;
  logic                   r_tvalid;
  logic                   r_tready;
  logic [RW-1:0]          r_tdata;
  logic [OW-1:0]          r_tkeep;
  logic                   r_tlast;
  logic [NREQ-1:0]        m_tvalid;
  logic [NREQ-1:0]        m_tready;
  logic [NREQ*RW-1:0]     m_tdata;
  logic [NREQ*OW-1:0]     m_tkeep;
  logic [NREQ-1:0]        m_tlast;
`ifdef AXIS_ARB_STATS_EN
  logic [NREQ*32-1:0]     stat_pkts;
  logic [31:0]            stat_stall;
`endif

  axis_processor_arbiter #(
    .NUM_REQ       (NREQ),
    .ID_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .p_tvalid (p_tvalid),
    .p_tready (p_tready),
    .p_tdata  (p_tdata),
    .p_tkeep  (p_tkeep),
    .p_tlast  (p_tlast),
    .r_tvalid (r_tvalid),
    .r_tready (r_tready),
    .r_tdata  (r_tdata),
    .r_tkeep  (r_tkeep),
    .r_tlast  (r_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast)
`ifdef AXIS_ARB_STATS_EN
    ,
    .stat_pkts  (stat_pkts),
    .stat_stall (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t  src_q [NREQ][$];
  rbeat_t proc_q[$];
  int     own_q[$];
  int     grants[$];
  int     resps[$];
  int     gtimes[$];

  int              cyc;
  int              p_pct, r_pct, m_pct;
  logic [NREQ-1:0] m_mask;
  bit              gaps, r_en, mid_pkt;
  int              cur_owner, last_owner;
  int              checks, errors;

  function automatic int rr_model();
    int idx;
    for (int j = 1; j <= NREQ; j++) begin
      idx = (last_owner + j) % NREQ;
      if (src_q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = mid_pkt || proc_q.size() > 0 || own_q.size() > 0;
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic add_pkt(input int req, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = DW'($urandom);
      b.l = (k == len - 1);
      src_q[req].push_back(b);
    end
  endtask

  task automatic drive();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = !(gaps && mid_pkt && cur_owner == i &&
                        $urandom_range(3) == 0);
        s_tdata[i*DW +: DW] = src_q[i][0].d;
        s_tlast[i]          = src_q[i][0].l;
        s_tkeep[i*IW +: IW] = '1;
      end
    end
    p_tready = ($urandom_range(99) < p_pct);
    r_tvalid = r_en && proc_q.size() > 0 &&
               ($urandom_range(99) < r_pct);
    r_tdata  = proc_q.size() > 0 ? proc_q[0].d : '0;
    r_tlast  = proc_q.size() > 0 ? proc_q[0].l : 1'b0;
    r_tkeep  = '1;
    for (int i = 0; i < NREQ; i++)
      m_tready[i] = m_mask[i] && ($urandom_range(99) < m_pct);
  endtask

  task automatic check_cycle();
    logic [NREQ-1:0] acc, exp_m, exp_l;
    logic            exp_r;
    int              k, e, ee;
    rbeat_t          rb;
    if (r_tvalid) begin
      e  = own_q.size() > 0 ? own_q[0] : -1;
      ee = e < 0 ? 0 : e;
      exp_m = '0;
      if (e >= 0) exp_m[ee] = 1'b1;
      exp_l = r_tlast ? exp_m : '0;
      exp_r = (e >= 0) ? m_tready[ee] : 1'b0;
      checks++;
      if (m_tvalid !== exp_m || m_tlast !== exp_l ||
          r_tready !== exp_r ||
          m_tdata[ee*RW +: RW] !== r_tdata) begin
        errors++;
        $display("FAIL resp_route cyc %0d m_tvalid %b want %b r_tready %b want %b",
                 cyc, m_tvalid, exp_m, r_tready, exp_r);
      end
      if (r_tready) begin
        void'(proc_q.pop_front());
        if (r_tlast && own_q.size() > 0)
          resps.push_back(own_q.pop_front());
      end
    end else begin
      checks++;
      if (m_tvalid !== '0) begin
        errors++;
        $display("FAIL m_idle cyc %0d m_tvalid %b want 0", cyc, m_tvalid);
      end
    end
    acc = s_tvalid & s_tready;
    checks++;
    if ((p_tvalid && p_tready) !== (acc != '0) ||
        $countones(acc) > 1) begin
      errors++;
      $display("FAIL p_hs cyc %0d s_tready %b p_tvalid %b", cyc, s_tready, p_tvalid);
    end
    if (acc != '0) begin
      k = 0;
      for (int i = 0; i < NREQ; i++) if (acc[i]) k = i;
      checks++;
      if (p_tdata !== src_q[k][0].d || p_tlast !== src_q[k][0].l) begin
        errors++;
        $display("FAIL p_data cyc %0d got %h want %h", cyc, p_tdata, src_q[k][0].d);
      end
      if (!mid_pkt) begin
        e = rr_model();
        checks++;
        if (k != e) begin
          errors++;
          $display("FAIL rr_order cyc %0d got %0d want %0d", cyc, k, e);
        end
        grants.push_back(k);
        gtimes.push_back(cyc);
        own_q.push_back(k);
        mid_pkt   = 1'b1;
        cur_owner = k;
      end else begin
        checks++;
        if (k != cur_owner) begin
          errors++;
          $display("FAIL grant_hold cyc %0d got %0d want %0d", cyc, k, cur_owner);
        end
      end
      rb.d = RW'(~src_q[k][0].d);
      rb.l = src_q[k][0].l;
      proc_q.push_back(rb);
      if (src_q[k][0].l) begin
        mid_pkt    = 1'b0;
        last_owner = k;
      end
      void'(src_q[k].pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    #1;
    check_cycle();
  endtask

  task automatic run_until(input int budget, input string name);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic reset_dut();
    arstn = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    proc_q.delete();
    own_q.delete();
    grants.delete();
    resps.delete();
    gtimes.delete();
    mid_pkt    = 1'b0;
    cur_owner  = 0;
    last_owner = NREQ - 1;
    p_pct = 100; r_pct = 100; m_pct = 100;
    m_mask = '1; gaps = 1'b0; r_en = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    p_tready = 1'b0; r_tvalid = 1'b0; r_tdata = '0;
    r_tkeep = '0; r_tlast = 1'b0; m_tready = '0;
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic test_reset();
    arstn    = 1'b0;
    s_tvalid = '1;
    p_tready = 1'b1;
    r_tvalid = 1'b1;
    r_tlast  = 1'b1;
    m_tready = '1;
    #23;
    checks++;
    if (s_tready !== '0) begin
      errors++; $display("FAIL rst_s_tready got %b want 0", s_tready);
    end
    checks++;
    if (p_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_p_tvalid got %b want 0", p_tvalid);
    end
    checks++;
    if (r_tready !== 1'b0) begin
      errors++; $display("FAIL rst_r_tready got %b want 0", r_tready);
    end
    checks++;
    if (m_tvalid !== '0) begin
      errors++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid);
    end
    reset_dut();
  endtask

  task automatic test_basic();
    reset_dut();
    add_pkt(2, 3);
    cycle();
    checks++;
    if (s_tready !== '0 || p_tvalid !== 1'b0) begin
      errors++; $display("FAIL basic_idle s_tready %b want 0", s_tready);
    end
    cycle();
    checks++;
    if (s_tready !== 4'b0100) begin
      errors++; $display("FAIL basic_grant s_tready %b want 0100", s_tready);
    end
    run_until(50, "basic");
    checks++;
    if (grants.size() != 1 || resps.size() != 1 ||
        grants[0] != 2 || resps[0] != 2) begin
      errors++;
      $display("FAIL basic_ids grants %0d resps %0d want 1/1 on lane 2",
               grants.size(), resps.size());
    end
    cycle();
    checks++;
    if (r_tready !== 1'b0) begin
      errors++; $display("FAIL basic_fifo_empty r_tready %b want 0", r_tready);
    end
  endtask

  task automatic test_round_robin();
    bit ok_g, ok_r, ok_t;
    reset_dut();
    for (int n = 0; n < 5; n++)
      for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
    run_until(200, "rr");
    ok_g = grants.size() == 20;
    ok_r = resps.size() == 20;
    ok_t = ok_g;
    for (int j = 0; j < 20 && ok_g && ok_r; j++) begin
      if (grants[j] != j % NREQ) ok_g = 1'b0;
      if (resps[j] != j % NREQ) ok_r = 1'b0;
      if (j > 0 && gtimes[j] - gtimes[j-1] != 2) ok_t = 1'b0;
    end
    checks++;
    if (!ok_g) begin
      errors++; $display("FAIL rr_grant_seq count %0d want 20 in 0,1,2,3 order", grants.size());
    end
    checks++;
    if (!ok_r) begin
      errors++; $display("FAIL rr_resp_seq count %0d want 20 in 0,1,2,3 order", resps.size());
    end
    checks++;
    if (!ok_t) begin
      errors++; $display("FAIL rr_two_cycle packet spacing not 2 cycles");
    end
`ifdef AXIS_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (stat_pkts[i*32 +: 32] !== 32'd5) begin
        errors++;
        $display("FAIL stat_pkts[%0d] got %0d want 5", i, stat_pkts[i*32 +: 32]);
      end
    end
`endif
  endtask

  task automatic test_fifo_full();
    reset_dut();
    r_en = 1'b0;
    for (int n = 0; n < 9; n++) add_pkt(1, 1);
    repeat (30) cycle();
    checks++;
    if (grants.size() != DEPTH) begin
      errors++; $display("FAIL full_grants got %0d want %0d", grants.size(), DEPTH);
    end
    checks++;
    if (s_tready !== '0 || p_tvalid !== 1'b0) begin
      errors++; $display("FAIL full_idle s_tready %b want 0", s_tready);
    end
    r_en = 1'b1;
    cycle();
    checks++;
    if (!(r_tvalid && r_tready && r_tlast) || s_tready !== '0) begin
      errors++;
      $display("FAIL full_pop r_tready %b s_tready %b want 1/0", r_tready, s_tready);
    end
    cycle();
    checks++;
    if (s_tready !== 4'b0010) begin
      errors++; $display("FAIL full_regrant s_tready %b want 0010", s_tready);
    end
    run_until(100, "full");
    checks++;
    if (grants.size() != 9 || resps.size() != 9) begin
      errors++;
      $display("FAIL full_total grants %0d resps %0d want 9", grants.size(), resps.size());
    end
`ifdef AXIS_ARB_STATS_EN
    checks++;
    if (stat_stall < 32'd14 || stat_stall > 32'd15) begin
      errors++; $display("FAIL stat_stall got %0d want 14..15", stat_stall);
    end
`endif
  endtask

  task automatic test_backpressure();
    reset_dut();
    add_pkt(1, 3);
    add_pkt(2, 2);
    m_mask = 4'b1101;
    repeat (20) cycle();
    checks++;
    if (r_tvalid !== 1'b1 || r_tready !== 1'b0 || m_tvalid !== 4'b0010) begin
      errors++;
      $display("FAIL bp_hold r_tready %b m_tvalid %b want 0/0010", r_tready, m_tvalid);
    end
    checks++;
    if (proc_q.size() != 5) begin
      errors++; $display("FAIL bp_no_loss pending %0d want 5", proc_q.size());
    end
    m_mask = '1;
    run_until(100, "bp");
    checks++;
    if (resps.size() != 2 || resps[0] != 1 || resps[1] != 2) begin
      errors++; $display("FAIL bp_order resps %0d want lanes 1 then 2", resps.size());
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    add_pkt(1, 1);
    run_until(50, "rm_pre");
    add_pkt(3, 4);
    repeat (3) cycle();
    #1 arstn = 1'b0;
    #1;
    checks++;
    if (s_tready !== '0 || p_tvalid !== 1'b0 ||
        r_tready !== 1'b0 || m_tvalid !== '0) begin
      errors++;
      $display("FAIL rm_async s_tready %b p_tvalid %b r_tready %b m_tvalid %b",
               s_tready, p_tvalid, r_tready, m_tvalid);
    end
    reset_dut();
    add_pkt(0, 2);
    add_pkt(3, 2);
    run_until(100, "rm_post");
    checks++;
    if (grants.size() != 2 || grants[0] != 0) begin
      errors++; $display("FAIL rm_first_grant count %0d want req 0 first", grants.size());
    end
  endtask

  task automatic test_random();
    int total;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      reset_dut();
      gaps  = 1'b1;
      p_pct = 70; r_pct = 70; m_pct = 70;
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
        int np;
        np = $urandom_range(4, 2);
        for (int n = 0; n < np; n++) add_pkt(i, $urandom_range(4, 1));
        total += np;
      end
      run_until(3000, "random");
      ok = grants.size() == total && resps.size() == total;
      for (int j = 0; j < resps.size() && ok; j++)
        if (resps[j] != grants[j]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_order grants %0d resps %0d want %0d",
                 grants.size(), resps.size(), total);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_fifo_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end
endmodule
